// File: rtl/id_ex_pipe_reg_pkg.sv
// rtl/id_ex_pipe_reg_pkg.sv - default widths, control bundle types and EX bundle bit positions for the ID/EX register
package id_ex_pkg;

    localparam int DEF_PC_W    = 8;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_REG_W   = 5;
    localparam int DEF_ALUOP_W = 2;
    localparam int DEF_M_W     = 3;
    localparam int DEF_WB_W    = 2;
    localparam int DEF_CNT_W   = 16;

    typedef struct packed {
        logic                   reg_dst;
        logic [DEF_ALUOP_W-1:0] alu_op;
        logic                   alu_src;
    } ex_ctrl_t;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
    } m_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    // EX bundle is {RegDst, ALUOp, ALUSrc}, MSB first; only RegDst moves with ALUOp width
    localparam int EX_ALUSRC_POS = 0;
    localparam int EX_ALUOP_LSB  = 1;

    function automatic int ex_regdst_pos(input int aluop_w);
        return aluop_w + 1;
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - decode-to-EX bundle with handshake; counters present only with ID_EX_PERF_CNT_EN
interface id_ex_pipe_reg_if #(
    parameter int PC_W    = 8,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2,
    parameter int M_W     = 3,
    parameter int WB_W    = 2,
    parameter int CNT_W   = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 flush;
    logic [PC_W-1:0]      next_pc_in;
    logic [DATA_W-1:0]    reg_data1_in;
    logic [DATA_W-1:0]    reg_data2_in;
    logic [DATA_W-1:0]    imm_in;
    logic [REG_W-1:0]     rs_in;
    logic [REG_W-1:0]     rt_in;
    logic [REG_W-1:0]     rd_in;
    logic [ALUOP_W+1:0]   ex_ctrl_in;
    logic [M_W-1:0]       m_ctrl_in;
    logic [WB_W-1:0]      wb_ctrl_in;
    logic                 out_ready;
    logic                 out_valid;
    logic [PC_W-1:0]      next_pc;
    logic [DATA_W-1:0]    reg_data1;
    logic [DATA_W-1:0]    reg_data2;
    logic [DATA_W-1:0]    imm;
    logic [REG_W-1:0]     rs;
    logic [REG_W-1:0]     rt;
    logic [REG_W-1:0]     rd;
    logic                 reg_dst;
    logic [ALUOP_W-1:0]   alu_op;
    logic                 alu_src;
    logic [M_W-1:0]       m_ctrl;
    logic [WB_W-1:0]      wb_ctrl;
`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     bubble_cnt;
`endif

    modport slave (
        input  in_valid, flush, next_pc_in, reg_data1_in, reg_data2_in, imm_in,
               rs_in, rt_in, rd_in, ex_ctrl_in, m_ctrl_in, wb_ctrl_in, out_ready,
        output in_ready, out_valid, next_pc, reg_data1, reg_data2, imm, rs, rt, rd,
               reg_dst, alu_op, alu_src, m_ctrl, wb_ctrl
`ifdef ID_EX_PERF_CNT_EN
        , output stall_cnt, bubble_cnt
`endif
    );

    modport master (
        output in_valid, flush, next_pc_in, reg_data1_in, reg_data2_in, imm_in,
               rs_in, rt_in, rd_in, ex_ctrl_in, m_ctrl_in, wb_ctrl_in, out_ready,
        input  in_ready, out_valid, next_pc, reg_data1, reg_data2, imm, rs, rt, rd,
               reg_dst, alu_op, alu_src, m_ctrl, wb_ctrl
`ifdef ID_EX_PERF_CNT_EN
        , input stall_cnt, bubble_cnt
`endif
    );

endinterface

// File: rtl/id_ex_pipe_reg_pipe_slice_en.sv
// rtl/id_ex_pipe_reg_pipe_slice_en.sv - generic enable/clear register slice, clear either zeroes or holds
module pipe_slice_en #(
    parameter int W          = 1,
    parameter bit CLEAR_ZERO = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset beats clear beats load; a clear on a hold-type slice simply keeps q
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= '0;
        end else if (clr) begin
            if (CLEAR_ZERO) begin
                q <= '0;
            end
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with handshake, flush and optional ID_EX_PERF_CNT_EN counters
module id_ex_pipe_reg
    import id_ex_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int ALUOP_W = DEF_ALUOP_W,
    parameter int M_W     = DEF_M_W,
    parameter int WB_W    = DEF_WB_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input logic             clk_id_ex,
    input logic             rst_n_id_ex,
    id_ex_pipe_reg_if.slave bus
);

    localparam int EX_W       = ALUOP_W + 2;
    localparam int REGDST_POS = ex_regdst_pos(ALUOP_W);
    localparam int DATA_BUS_W = PC_W + 3 * DATA_W + 3 * REG_W;
    localparam int CTRL_BUS_W = 1 + EX_W + M_W + WB_W;

    logic                  ready;
    logic                  hold;
    logic                  load;
    logic                  bubble;
    logic [DATA_BUS_W-1:0] data_d;
    logic [DATA_BUS_W-1:0] data_q;
    logic [CTRL_BUS_W-1:0] ctrl_d;
    logic [CTRL_BUS_W-1:0] ctrl_q;
    logic [EX_W-1:0]       ex_q;

    // Flush always frees the slot, even while EX is stalled
    assign ready  = !bus.out_valid | bus.out_ready | bus.flush;
    assign hold   = !ready;
    assign load   = bus.in_valid & ready & !bus.flush;
    assign bubble = bus.flush | (ready & !bus.in_valid);

    assign bus.in_ready = ready;

    assign data_d = {bus.next_pc_in, bus.reg_data1_in, bus.reg_data2_in, bus.imm_in,
                     bus.rs_in, bus.rt_in, bus.rd_in};
    // valid rides with the controls so a bubble zeroes both together
    assign ctrl_d = {1'b1, bus.ex_ctrl_in, bus.m_ctrl_in, bus.wb_ctrl_in};

    pipe_slice_en #(.W(DATA_BUS_W), .CLEAR_ZERO(1'b0)) u_data (
        .clk    (clk_id_ex),
        .resetn (rst_n_id_ex),
        .en     (load),
        .clr    (bubble),
        .d      (data_d),
        .q      (data_q)
    );

    pipe_slice_en #(.W(CTRL_BUS_W), .CLEAR_ZERO(1'b1)) u_ctrl (
        .clk    (clk_id_ex),
        .resetn (rst_n_id_ex),
        .en     (load),
        .clr    (bubble),
        .d      (ctrl_d),
        .q      (ctrl_q)
    );

    assign {bus.next_pc, bus.reg_data1, bus.reg_data2, bus.imm,
            bus.rs, bus.rt, bus.rd} = data_q;
    assign {bus.out_valid, ex_q, bus.m_ctrl, bus.wb_ctrl} = ctrl_q;

    assign bus.reg_dst = ex_q[REGDST_POS];
    assign bus.alu_op  = ex_q[EX_ALUOP_LSB +: ALUOP_W];
    assign bus.alu_src = ex_q[EX_ALUSRC_POS];

`ifdef ID_EX_PERF_CNT_EN
    // Saturating stall/bubble counters, cleared only by reset
    always_ff @(posedge clk_id_ex) begin
        if (!rst_n_id_ex) begin
            bus.stall_cnt  <= '0;
            bus.bubble_cnt <= '0;
        end else begin
            if (hold && (bus.stall_cnt != {CNT_W{1'b1}})) begin
                bus.stall_cnt <= bus.stall_cnt + 1'b1;
            end
            if (bubble && (bus.bubble_cnt != {CNT_W{1'b1}})) begin
                bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline register for the 5-stage MIPS core. It is the next-generation replacement for the fixed-width ID/EX buffer.
- Adds a valid/ready handshake so a stall in EX holds the entry without loss.
- Adds a flush input that turns the entry into a bubble, for branch and jump squash.
- Adds a configurable ALUOp width and forwards rs for the forwarding unit.
- Sits between the decode/register-file stage and the EX stage (ALU, ALU control, dest mux).

Parameters:
PC_W, 8, width of the next-instruction (PC+4) field
DATA_W, 32, width of register-data and sign-extended immediate fields
REG_W, 5, register-index width
ALUOP_W, 2, ALUOp width; the EX control bundle is {RegDst, ALUOp, ALUSrc}
M_W, 3, MEM-stage control width
WB_W, 2, WB-stage control width
CNT_W, 16, perf-counter width (used only with the optional feature)

Ports:
clk_id_ex  in  1  clock; everything samples on the rising edge
rst_n_id_ex  in  1  reset; synchronous, active-low
in_valid  in  1  decode stage presents a valid instruction
in_ready  out  1  register can accept this cycle
flush  in  1  squash the held entry and the incoming entry
next_pc_in  in  PC_W  PC+4 from the adder
reg_data1_in  in  DATA_W  rs register value
reg_data2_in  in  DATA_W  rt register value
imm_in  in  DATA_W  sign-extended bits 15:0
rs_in, rt_in, rd_in  in  REG_W  register indices
ex_ctrl_in  in  ALUOP_W+2  {RegDst, ALUOp, ALUSrc}, MSB first
m_ctrl_in  in  M_W  MEM controls
wb_ctrl_in  in  WB_W  WB controls
out_ready  in  1  EX stage can consume the entry
out_valid  out  1  entry is valid
next_pc, reg_data1, reg_data2, imm, rs, rt, rd  out  (widths as the inputs)  registered copies
reg_dst  out  1  to the destination mux
alu_op  out  ALUOP_W  to ALU control
alu_src  out  1  to the ALU operand mux
m_ctrl  out  M_W  forwarded to EX/MEM
wb_ctrl  out  WB_W  forwarded to EX/MEM

Behaviour:
- in_ready is combinational: in_ready = !out_valid | out_ready | flush. There is no registered path.
- Latency is 1 cycle. Throughput is 1 entry per cycle while out_ready=1.
- Priority on each rising edge: reset, then flush, then hold, then load, then drain.
  - Reset (rst_n_id_ex=0): every output is 0, including out_valid, all data and all control.
  - Flush (flush=1): out_valid<=0; reg_dst, alu_op, alu_src, m_ctrl and wb_ctrl <=0. The incoming entry is dropped even if in_valid=1. Data fields hold their values.
  - Hold (out_valid=1 & out_ready=0): all outputs keep their values. Inputs are ignored.
  - Load (in_valid=1 & in_ready=1): every field is captured, ex_ctrl_in is split into its three controls, and out_valid<=1.
  - Drain (in_ready=1 & in_valid=0): out_valid<=0 and controls <=0, giving a bubble. Data fields hold.
- Control fields are 0 whenever out_valid=0. Downstream may therefore ignore out_valid for the write-enable paths.
- Reset asserted in the middle of a stall discards the held entry. The first cycle after reset release has out_valid=0.
- flush asserted together with out_ready=0 still clears the entry. Flush overrides the stall.
- No combinational path from any data input to any output.

Optional Feature:
Macro ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt[CNT_W] and bubble_cnt[CNT_W].
  - stall_cnt increments on every hold cycle.
  - bubble_cnt increments on every flush or drain cycle.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent and the rest of the behaviour is unchanged.

Decomposition:
- Package id_ex_pkg holds:
  - default width constants;
  - packed structs ex_ctrl_t {reg_dst, alu_op, alu_src}, m_ctrl_t and wb_ctrl_t;
  - constants for the bit positions of RegDst, ALUOp and ALUSrc in the EX bundle.
- One sub-module, pipe_slice_en: a generic enable/clear register of parameter width with synchronous active-low reset. It is instantiated once for the data fields (hold-on-clear) and once for the control fields (zero-on-clear).

Test Plan:
- Reset with rst_n_id_ex=0 for 2 cycles and all inputs at 1 -> all outputs 0, out_valid=0. Release with in_valid=0 -> outputs stay 0.
- Streaming: in_valid=1, out_ready=1, ex_ctrl_in=4'b1101, reg_data1_in=32'hDEADBEEF, rd_in=5'd9 -> next cycle out_valid=1, reg_dst=1, alu_op=2'b10, alu_src=1, reg_data1=32'hDEADBEEF, rd=9. Back-to-back entries appear on consecutive cycles.
- Stall: entry A valid, out_ready=0 for 3 cycles, entry B presented -> in_ready=0 and A held unchanged for 3 cycles. B appears the cycle after out_ready returns to 1.
- Flush during stall: A held, out_ready=0, flush=1 with B at the input -> next cycle out_valid=0, reg_dst, alu_op, alu_src, m_ctrl and wb_ctrl all 0. B is never output.
- Drain: out_ready=1, in_valid=0 after entry A -> out_valid=0, controls 0, reg_data2 still equals A's value.
- With ID_EX_PERF_CNT_EN and CNT_W=4: 20 stall cycles -> stall_cnt=4'hF (saturated). 3 flush cycles -> bubble_cnt=3.
